// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and helpers for the round-robin mux arbiter.
// Imported by the priority search and by the arbiter top.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority search: returns the first requester set in the order
// ptr+1, ptr+2, ptr+3, ptr (mod 4). Purely combinational.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from lowest priority to highest so the earliest match in search order wins.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select pair of the shared 4:1 mux datapath;
// holds each grant for up to MAX_BURST accepted beats, then rotates priority.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic               last
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t         state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               accept;
  logic               owner_req;
  logic               burst_done;
  logic               release_now;

  // In GRANT, ptr is the current owner, so one search serves both the idle pick and the handover.
  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign valid       = (state == GRANT);
  assign last        = valid && (cnt == CNT_LAST);
  assign accept      = ready && valid;
  assign owner_req   = req[ptr];
  assign burst_done  = accept && (cnt == CNT_LAST);
  assign release_now = !owner_req || burst_done;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    sel_nxt   = sel;

    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (pick_any) begin
          state_nxt = GRANT;
          gnt_nxt   = onehot4(pick_idx);
          sel_nxt   = pick_idx;
          ptr_nxt   = pick_idx;
          cnt_nxt   = '0;
        end
      end

      GRANT: begin
        if (release_now) begin
          if (pick_any) begin
            gnt_nxt = onehot4(pick_idx);
            sel_nxt = pick_idx;
            ptr_nxt = pick_idx;
            cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            cnt_nxt   = '0;
          end
        end else if (accept) begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ptr resets to 3 so requester 0 is first in line after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ptr   <= SEL_W'(NUM_REQ - 1);
      cnt   <= '0;
      gnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: two instances (MAX_BURST=4 and 1) share
// stimulus; a queue-based reference model predicts every cycle's outputs.
module tb_mux_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       last;
  } obs_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ready = 1'b0;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       valid_a, valid_b;
  logic       last_a, last_b;

  int vectors = 0;
  int miscompares = 0;

  obs_t exp_q_a[$];
  obs_t exp_q_b[$];

  int m_owner[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_sel[2];
  int m_max[2] = '{4, 1};

  mux_rr_arbiter #(.MAX_BURST(4)) dut_a (
    .clk(clk), .rstn(rstn), .req(req), .ready(ready),
    .gnt(gnt_a), .sel(sel_a), .valid(valid_a), .last(last_a)
  );

  mux_rr_arbiter #(.MAX_BURST(1)) dut_b (
    .clk(clk), .rstn(rstn), .req(req), .ready(ready),
    .gnt(gnt_b), .sel(sel_b), .valid(valid_b), .last(last_b)
  );

  always #5 clk = ~clk;

  // First requester found in the order p+1, p+2, p+3, p; -1 when nobody asks.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset(input int d);
    m_owner[d] = -1;
    m_ptr[d]   = 3;
    m_cnt[d]   = 0;
    m_sel[d]   = 0;
  endfunction

  function automatic void model_grant(input int d, input int p);
    m_owner[d] = p;
    m_ptr[d]   = p;
    m_sel[d]   = p;
    m_cnt[d]   = 0;
  endfunction

  function automatic void model_step(input int d, input logic [3:0] r, input logic rd);
    int p;
    if (m_owner[d] < 0) begin
      p = pick(r, m_ptr[d]);
      if (p >= 0) model_grant(d, p);
    end else if (!r[m_owner[d]] || (rd && m_cnt[d] == m_max[d] - 1)) begin
      p = pick(r, m_owner[d]);
      if (p >= 0) model_grant(d, p);
      else m_owner[d] = -1;
    end else if (rd) begin
      m_cnt[d] = m_cnt[d] + 1;
    end
  endfunction

  function automatic obs_t model_obs(input int d);
    obs_t o;
    o.valid = (m_owner[d] >= 0);
    o.gnt   = o.valid ? 4'(1 << m_owner[d]) : 4'b0000;
    o.sel   = 2'(m_sel[d]);
    o.last  = o.valid && (m_cnt[d] == m_max[d] - 1);
    return o;
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t: got gnt=%b sel=%b valid=%b last=%b, want gnt=%b sel=%b valid=%b last=%b",
               name, $time, act.gnt, act.sel, act.valid, act.last,
               exp.gnt, exp.sel, exp.valid, exp.last);
    end
  endtask

  // One cycle of stimulus; expected post-edge outputs go to the scoreboard.
  task automatic applyStimulus(input logic [3:0] r, input logic rd, input logic rst);
    @(negedge clk);
    req   = r;
    ready = rd;
    if (rst) begin
      rstn = 1'b0;
      model_reset(0);
      model_reset(1);
      #1;
      checkOutput("reset_now_a", {gnt_a, sel_a, valid_a, last_a}, model_obs(0));
      checkOutput("reset_now_b", {gnt_b, sel_b, valid_b, last_b}, model_obs(1));
    end else begin
      rstn = 1'b1;
      model_step(0, r, rd);
      model_step(1, r, rd);
    end
    exp_q_a.push_back(model_obs(0));
    exp_q_b.push_back(model_obs(1));
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q_a.size() > 0) begin
        e = exp_q_a.pop_front();
        checkOutput("cycle_a", {gnt_a, sel_a, valid_a, last_a}, e);
      end
      if (exp_q_b.size() > 0) begin
        e = exp_q_b.pop_front();
        checkOutput("cycle_b", {gnt_b, sel_b, valid_b, last_b}, e);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] r;
    logic       rd;
    logic       rst;

    model_reset(0);
    model_reset(1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);

    // Lone requester 0 with the consumer always ready.
    for (int i = 0; i < 10; i++) applyStimulus(4'b0001, 1'b1, 1'b0);

    // Everyone requesting: full rotation.
    for (int i = 0; i < 20; i++) applyStimulus(4'b1111, 1'b1, 1'b0);

    // Stalled owner, then it drops its request.
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 1'b0, 1'b0);

    // Owner 2 drops on its final beat with requester 3 waiting, then all idle.
    applyStimulus(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b1, 1'b0);

    // Reset in the middle of a burst owned by requester 3.
    for (int i = 0; i < 3; i++) applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(4'b1010, 1'b1, 1'b0);

    // Alternating pair.
    for (int i = 0; i < 8; i++) applyStimulus(4'b0101, 1'b1, 1'b0);

    // Randomized traffic with sticky requests and occasional resets.
    r = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      rd  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus(r, rd, rst);
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q_a.size() + exp_q_b.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0",
               exp_q_a.size() + exp_q_b.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

- Round-robin arbiter and sequencer for the shared 4:1 NAND-built multiplexer datapath.
- Four requesters compete for the mux. The block grants one at a time and drives the mux select pair (s1, s0) to the owner's index.
- It holds each grant for a burst of accepted beats, then rotates priority.
- It sits between the requester logic and the per-bit mux instances; the consumer on the mux output handshakes via `ready`.

## Interface
- `MAX_BURST`, default 4: maximum accepted beats per grant, legal range 1..16.
- `clk  input  1`: rising-edge clock.
- `rstn  input  1`: asynchronous, active-low reset.
- `req  input  4`: request per requester; bit i = requester i; level-sensitive.
- `ready  input  1`: consumer accepts the current beat when `ready` and `valid` are both high.
- `gnt  output  4`: one-hot grant, all-zero when idle; registered.
- `sel  output  2`: mux select, `sel[1]`→s1, `sel[0]`→s0; equals the owner index; registered.
- `valid  output  1`: a grant is active; equals `|gnt`.
- `last  output  1`: high while the current beat is the final beat of the burst (count = MAX_BURST-1).

## Operation
- States: IDLE, GRANT.
- Priority pointer `ptr` holds the last owner index. The search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
- IDLE:
  - `gnt`=0; `sel` holds the last owner index (mux output stays stable).
  - If `|req`, pick the first set bit in search order. Next cycle: `gnt` = one-hot(pick), `sel` = pick, `ptr` = pick, beat count = 0, go to GRANT.
- GRANT:
  - An accepted beat is `ready && valid`. Each accepted beat increments the beat count.
- Release happens on either condition, evaluated in the same cycle:
  - (a) `req[owner]` is low.
  - (b) An accepted beat occurs while count = MAX_BURST-1.
- On release, the next owner is picked from the current `req` in search order starting at owner+1.
  - If `req[owner]` is still high it is eligible, but last in the search order.
  - If nothing is eligible, go to IDLE with `gnt`=0.
  - Otherwise grant the new owner next cycle with count reset to 0. There is no bubble cycle.
- Precedence: (a) dominates (b). An owner that drops `req` in the same cycle as a final accepted beat is released once.
- `ready` while `valid`=0 is ignored.
- Requests arriving mid-burst do not preempt the owner.
- Beat-count width is max(1, $clog2(MAX_BURST)).
- MAX_BURST=1: release after every accepted beat. A lone requester is re-granted back-to-back with `gnt` continuously high.

## Timing
- Reset values (asynchronous, immediate on `rstn` low): `gnt`=0, `sel`=0, `valid`=0, `last`=0, `ptr`=3 (first priority is requester 0), count=0, state=IDLE.
- Reset mid-burst: grant drops immediately. After `rstn` deasserts, arbitration restarts from requester 0.
- Request to grant: 1 cycle (`req` sampled at edge N, `gnt` high after edge N).
- Release to next grant: 0 bubble cycles. The handover edge changes `gnt` and `sel` together.
- All outputs are registered except `valid` and `last`, which decode registered state only. There is no combinational path from `req`/`ready` to any output.
- `sel` never changes while `valid` is high except on the handover edge.

## Structure
- Package `mux_arb_pkg` holds:
  - `NUM_REQ` = 4 and `SEL_W` = 2.
  - State enum `arb_state_t` {IDLE, GRANT}.
  - Function `onehot4(idx)`.
- Sub-module `rr_pick`: combinational; inputs `req[3:0]`, `ptr[1:0]`; outputs `any`, `idx[1:0]`. Implements the rotated priority search, used for both the IDLE and release picks.
- Top `mux_rr_arbiter`: state register, ptr, beat counter, output registers.

## Test plan
- Reset, then `req`=4'b0001: next edge `gnt`=0001, `sel`=00, `valid`=1; after 4 accepted beats (`ready`=1, MAX_BURST=4) requester 0 is re-granted with zero bubble and count restarts.
- `req`=4'b1111, `ready`=1, MAX_BURST=4: grants rotate 0→1→2→3→0; each grant lasts 4 cycles; `last` is high on the 4th cycle of each burst.
- `req`=4'b0110 with owner 1, `ready`=0 for 10 cycles: grant holds at `sel`=01, `last`=0 throughout; `req[1]` drops → next edge `gnt`=0100, `sel`=10.
- Owner 2 drops `req` on the same edge as its final accepted beat, with `req`=4'b1000 otherwise: exactly one release, next `gnt`=1000, `sel`=11; then all `req`=0 → IDLE, `gnt`=0, `sel` stays 11.
- `rstn` pulsed low mid-burst with owner 3: `gnt`=0, `sel`=00 immediately; after release with `req`=4'b1010, requester 1 is granted first.
- MAX_BURST=1, `req`=4'b0101, `ready`=1: grants alternate 0,2,0,2 every cycle with `valid` continuously high.
